fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-port arbiter for the `fifo` block. It shares the single FIFO write port (`w_en`/`w_data`/`w_full`) among `NUM_REQ` producers in the `w_clk` domain. Grants are burst-limited so that no producer can hold the port indefinitely. The arbiter sits directly in front of `fifo`; its `w_en`/`w_data` drive the FIFO, and `w_full` is returned from it.

## Interface
- `NUM_REQ`, 4: number of requesters; minimum 2.
- `DATA_W`, 8: word width; must match the FIFO.
- `BURST_MAX`, 16: maximum beats per grant; minimum 1.
- `w_clk` input 1: write-domain clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester word valid.
- `req_data` input NUM_REQ*DATA_W: flat data, requester i at bits [i*DATA_W +: DATA_W].
- `req_ready` output NUM_REQ: word of requester i accepted this cycle.
- `grant` output NUM_REQ: registered one-hot current owner; 0 when idle.
- `w_full` input 1: FIFO full flag.
- `w_en` output 1: FIFO write enable.
- `w_data` output DATA_W: FIFO write data.
- `busy` output 1: state is GRANT.

## Operation
- FSM with two states, IDLE and GRANT. Registers: `state`, `owner` index, `rr_ptr` index, `beat_cnt` of width $clog2(BURST_MAX+1).
- IDLE: if any `req_valid` bit is set, pick the first set bit at or after `rr_ptr`, scanning upward modulo NUM_REQ. On the next edge: `owner` takes the picked index, `grant` becomes one-hot of it, `beat_cnt` is 0, and the state moves to GRANT.
- GRANT: `w_en = req_valid[owner] & ~w_full`. `req_ready[owner] = w_en`. All other `req_ready` bits are 0. `w_data = req_data[owner]`, which is muxed even when `w_en` is 0.
- On each `w_en` beat, `beat_cnt` increments.
- Release to IDLE happens on either condition:
  - a beat occurs with `beat_cnt == BURST_MAX-1`;
  - a cycle in GRANT has `req_valid[owner] == 0`.
- On release: `rr_ptr` takes `(owner+1) mod NUM_REQ`, and `grant` clears.
- If `w_full` is high while the owner is valid, the grant is held. This is a stall, not a release. `beat_cnt` is unchanged during a stall.
- Requester rule: `req_data` stays stable while `req_valid & ~req_ready`. A requester may drop `req_valid` at any time; doing so ends its grant.
- In IDLE: `w_en = 0` and `req_ready = 0`.

## Timing
- Reset values: `state` is IDLE, `grant` is 0, `rr_ptr` is 0, `beat_cnt` is 0, `owner` is 0. Combinationally this gives `w_en = 0`, `req_ready = 0`, `busy = 0`. `w_data` equals `req_data[0]`, which is don't-care.
- Arbitration latency: `req_valid` seen in IDLE at edge n gives a grant after edge n, so the first beat can occur in cycle n+1.
- Release cost: one IDLE bubble cycle between grants.
- Peak throughput: BURST_MAX beats per BURST_MAX+1 cycles.
- `w_en` is combinational from registered `state`/`owner` plus `req_valid`/`w_full`. There is no register on the write path, so full-flag response is zero-cycle.
- BURST_MAX=1: every beat releases. Grants alternate between the requester and an IDLE cycle.
- Reset asserted mid-burst: everything clears asynchronously, and `w_en` falls in the same cycle. After reset, requester 0 has priority.
- Simultaneous requests in IDLE: round-robin from `rr_ptr`. Requests arriving during GRANT wait.

## Configuration
- Macro: `FIFO_WR_ARB_STATS_EN`.
- Defined:
  - adds output `beat_total`, NUM_REQ*16 bits: per-requester count of accepted beats, wrapping at 2^16;
  - adds output `stall_cnt`, 16 bits: cycles in GRANT with `req_valid[owner] & w_full`, saturating at 0xFFFF;
  - both counters reset to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Package `fifo_wr_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT);
  - the stats counter width constant (16);
  - the index-width function.
- Sub-module `fifo_wr_arb_rr_pick`: combinational round-robin picker. Inputs are `req` and `ptr`; outputs are `found` and `idx`. It is instantiated once.
- The top level holds the FSM, counters, output mux and the optional stats.

## Test plan
- Single requester: reset, then requester 0 streams 20 words 0..19 with BURST_MAX=16. Expected: `w_data` 0..15 on 16 consecutive `w_en`; one IDLE cycle; re-grant to 0; then 16..19.
- Contention: all four requesters continuously valid. Expected: grant order 0,1,2,3,0; 16 beats each; exactly one bubble between grants.
- Back-pressure: `w_full` held high for 5 cycles after beat 7 of requester 1. Expected: `w_en` and `req_ready` low for those 5 cycles; grant held; beats 8..15 resume in order with no loss or duplicate.
- Early release: with `rr_ptr`=2, requester 2 drops `req_valid` after 3 beats while requesters 1 and 3 are valid. Expected: release, then the next grant goes to 3, then 1.
- Reset mid-burst: `rst_n` low at beat 5 of requester 3. Expected: `grant`=0 and `w_en`=0 immediately; after release, with requesters 0 and 3 both valid, requester 0 wins.
- Stats with `FIFO_WR_ARB_STATS_EN` defined: drive 258 words from requester 0 into a full-stalling FIFO model. Expected: `beat_total[0]`=258, and `stall_cnt` equals the number of cycles the model held `w_full` during GRANT.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (StIdle, StGrant)
//   StatsW      : width of each optional statistics counter
//   idx_width() : bits needed to index n requesters (at least 1)
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_t;

  localparam int unsigned StatsW = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// fifo_wr_arb_rr_pick: combinational round-robin picker.
// Finds the first set bit of req at or after ptr, scanning upward modulo NUM_REQ.
//   req   : request vector
//   ptr   : index where the scan starts (highest priority)
//   found : any request bit set
//   idx   : picked index (0 when nothing is found)
module fifo_wr_arb_rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic               found,
  output logic [IdxW-1:0]    idx
);

  logic [IdxW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: burst-limited round-robin arbiter sharing one FIFO write port
// among NUM_REQ producers in the w_clk domain.
//   w_clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_data    : per-requester word offer (requester i at [i*DATA_W +: DATA_W])
//   req_ready             : requester's word accepted this cycle
//   grant                 : registered one-hot owner, 0 when idle
//   w_full                : FIFO full flag
//   w_en/w_data           : FIFO write port
//   busy                  : arbiter is in the grant state
// Optional build macro FIFO_WR_ARB_STATS_EN adds:
//   beat_total            : per-requester accepted-beat counters (wrapping)
//   stall_cnt             : grant cycles stalled by w_full (saturating)
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                        w_clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          grant,
  input  logic                        w_full,
  output logic                        w_en,
  output logic [DATA_W-1:0]           w_data,
  output logic                        busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*StatsW-1:0]   beat_total,
  output logic [StatsW-1:0]           stall_cnt
`endif
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(BURST_MAX + 1);
  localparam logic [CntW-1:0] BurstLast = CntW'(BURST_MAX - 1);

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic                pick_found;
  logic [IdxW-1:0]     pick_idx;
  logic                in_grant;
  logic                owner_valid;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [IdxW-1:0]     next_ptr;

  fifo_wr_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Write path is purely combinational so a rising w_full blocks the beat in
  // the same cycle.
  always_comb begin
    in_grant    = (state_q == StGrant);
    owner_valid = req_valid[owner_q];
    owner_oh    = NUM_REQ'(1) << owner_q;
    w_en        = in_grant & owner_valid & ~w_full;
    req_ready   = w_en ? owner_oh : '0;
    // Muxed even when idle or stalled; consumers qualify with w_en.
    w_data      = DATA_W'(req_data >> (32'(owner_q) * DATA_W));
    next_ptr    = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StGrant;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          beat_cnt_d        = '0;
        end
      end
      StGrant: begin
        // Release when the owner withdraws or its final burst beat goes out.
        // A w_full stall with the owner still valid holds everything.
        if (!owner_valid || (w_en && (beat_cnt_q == BurstLast))) begin
          state_d    = StIdle;
          grant_d    = '0;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (w_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = in_grant;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*StatsW-1:0] beat_total_q, beat_total_d;
  logic [StatsW-1:0]         stall_cnt_q, stall_cnt_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat
    assign beat_total_d[g*StatsW +: StatsW] =
        beat_total_q[g*StatsW +: StatsW] + StatsW'(req_ready[g]);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_grant && owner_valid && w_full && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_total_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      beat_total_q <= beat_total_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign beat_total = beat_total_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed self-checking bench for fifo_wr_arb
// (NUM_REQ=4, DATA_W=8, BURST_MAX=16).
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            w_clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic            w_full;
  logic            w_en;
  logic [DW-1:0]   w_data;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*16-1:0] beat_total;
  logic [15:0]      stall_cnt;
`endif

  fifo_wr_arb #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .BURST_MAX (16)
  ) dut (
    .w_clk     (w_clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .w_full    (w_full),
    .w_en      (w_en),
    .w_data    (w_data),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_total (beat_total),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Producer model: requester i offers base[i]+word[i] while word[i] < limit[i].
  int   word  [NR];
  int   limit [NR];
  int   base  [NR];
  bit   vld_en[NR];

  // Early-release scenario: expected grant, w_en and w_data per cycle.
  int t4_g [20] = '{0, 2, 2, 0, 4, 4, 4, 4, 0, 8, 8, 8, 8, 8, 0, 2, 2, 2, 2, 2};
  int t4_en[20] = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
  int t4_d [20] = '{0, 64, 0, 0, 128, 129, 130, 0, 0, 192, 193, 194, 195, 0, 0,
                    65, 66, 67, 68, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = vld_en[i] && (word[i] < limit[i]);
      req_data[i*DW +: DW]  = DW'(base[i] + word[i]);
    end
  endtask

  // Apply this cycle's inputs and let the combinational outputs settle.
  task automatic settle();
    drive();
    #1;
  endtask

  // Record accepted words, then move to the next cycle's drive point.
  task automatic advance();
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) word[i]++;
    end
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      word[i]   = 0;
      limit[i]  = 0;
      vld_en[i] = 1'b0;
      base[i]   = i * 64;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    w_full = 1'b0;
    clear_model();
    drive();
    repeat (2) @(negedge w_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    w_full = 1'b0;
    clear_model();

    // Reset state, with every requester asserting valid.
    for (int i = 0; i < NR; i++) begin
      vld_en[i] = 1'b1;
      limit[i]  = 100;
    end
    drive();
    @(posedge w_clk);
    @(negedge w_clk);
    #1;
    check_eq("rst grant", grant, 0);
    check_eq("rst w_en", w_en, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst req_ready", req_ready, 0);

    // Single requester: 20 words, burst of 16, one bubble, then 4 more.
    do_reset();
    vld_en[0] = 1'b1;
    limit[0]  = 20;
    for (int c = 0; c <= 22; c++) begin
      bit en1;
      bit g1;
      int d;
      settle();
      en1 = (c >= 1 && c <= 16) || (c >= 18 && c <= 21);
      g1  = en1 || (c == 22);
      d   = (c <= 16) ? c - 1 : c - 2;
      check_eq($sformatf("t1 w_en c%0d", c), w_en, en1);
      check_eq($sformatf("t1 grant c%0d", c), grant, g1 ? 1 : 0);
      if (en1) check_eq($sformatf("t1 w_data c%0d", c), w_data, d);
      advance();
    end
    check_eq("t1 words sent", word[0], 20);

    // Contention: all four valid; order 0,1,2,3,0 with one bubble between grants.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      vld_en[i] = 1'b1;
      limit[i]  = 60;
    end
    for (int c = 0; c <= 84; c++) begin
      int k;
      int pos;
      int r;
      settle();
      if (c == 0) begin
        check_eq("t2 grant c0", grant, 0);
        check_eq("t2 w_en c0", w_en, 0);
      end else begin
        k   = (c - 1) / 17;
        pos = (c - 1) % 17;
        r   = k % NR;
        if (pos < 16) begin
          check_eq($sformatf("t2 grant c%0d", c), grant, 1 << r);
          check_eq($sformatf("t2 req_ready c%0d", c), req_ready, 1 << r);
          check_eq($sformatf("t2 w_data c%0d", c), w_data, r * 64 + (k / NR) * 16 + pos);
        end else begin
          check_eq($sformatf("t2 bubble grant c%0d", c), grant, 0);
          check_eq($sformatf("t2 bubble w_en c%0d", c), w_en, 0);
        end
      end
      advance();
    end

    // Back-pressure: w_full high for 5 cycles after beat 7 of requester 1.
    do_reset();
    vld_en[1] = 1'b1;
    limit[1]  = 16;
    for (int c = 0; c <= 22; c++) begin
      bit stall;
      bit en1;
      stall  = (c >= 9 && c <= 13);
      w_full = stall;
      settle();
      en1 = (c >= 1 && c <= 21) && !stall;
      check_eq($sformatf("t3 w_en c%0d", c), w_en, en1);
      check_eq($sformatf("t3 req_ready c%0d", c), req_ready, en1 ? 4'b0010 : 4'b0000);
      check_eq($sformatf("t3 grant c%0d", c), grant, (c >= 1 && c <= 21) ? 4'b0010 : 4'b0000);
      if (c >= 1 && c <= 8) check_eq($sformatf("t3 w_data c%0d", c), w_data, 64 + c - 1);
      if (stall) check_eq($sformatf("t3 stall data c%0d", c), w_data, 72);
      if (c >= 14 && c <= 21) check_eq($sformatf("t3 w_data c%0d", c), w_data, 64 + c - 6);
      advance();
    end
    w_full = 1'b0;
    check_eq("t3 words sent", word[1], 16);

    // Early release: rr_ptr moved to 2, requester 2 drops after 3 beats.
    do_reset();
    vld_en[1] = 1'b1;
    limit[1]  = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin
        limit[1]  = 5;
        vld_en[2] = 1'b1;
        limit[2]  = 3;
        vld_en[3] = 1'b1;
        limit[3]  = 4;
      end
      settle();
      check_eq($sformatf("t4 grant c%0d", c), grant, t4_g[c]);
      check_eq($sformatf("t4 w_en c%0d", c), w_en, t4_en[c]);
      if (t4_en[c] != 0) check_eq($sformatf("t4 w_data c%0d", c), w_data, t4_d[c]);
      advance();
    end

    // Reset mid-burst at beat 5 of requester 3, then requester 0 wins.
    do_reset();
    vld_en[3] = 1'b1;
    limit[3]  = 100;
    for (int c = 0; c <= 6; c++) begin
      settle();
      check_eq($sformatf("t5 w_en c%0d", c), w_en, (c >= 1) ? 1 : 0);
      if (c >= 1) check_eq($sformatf("t5 w_data c%0d", c), w_data, 192 + c - 1);
      if (c < 6) advance();
    end
    rst_n = 1'b0;
    #1;
    check_eq("t5 async grant", grant, 0);
    check_eq("t5 async w_en", w_en, 0);
    check_eq("t5 async busy", busy, 0);
    check_eq("t5 async req_ready", req_ready, 0);
    @(negedge w_clk);
    clear_model();
    vld_en[0] = 1'b1;
    limit[0]  = 10;
    vld_en[3] = 1'b1;
    limit[3]  = 10;
    rst_n     = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      settle();
      check_eq($sformatf("t5 post grant c%0d", c), grant, (c >= 1) ? 4'b0001 : 4'b0000);
      check_eq($sformatf("t5 post w_en c%0d", c), w_en, (c >= 1) ? 1 : 0);
      if (c >= 1) check_eq($sformatf("t5 post w_data c%0d", c), w_data, c - 1);
      advance();
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Stats: 258 words from requester 0 into a periodically full FIFO.
    begin
      int exp_stall;
      int cyc;
      exp_stall = 0;
      cyc       = 0;
      do_reset();
      vld_en[0] = 1'b1;
      limit[0]  = 258;
      while (word[0] < 258 && cyc < 3000) begin
        w_full = ((cyc % 7) == 3) || ((cyc % 11) == 5);
        settle();
        if (grant[0] && req_valid[0] && w_full) exp_stall++;
        advance();
        cyc++;
      end
      w_full = 1'b0;
      check_eq("stats all words sent", word[0], 258);
      settle();
      advance();
      settle();
      check_eq("stats beat_total[0]", beat_total[15:0], 258);
      check_eq("stats beat_total[1]", beat_total[31:16], 0);
      check_eq("stats stall_cnt", stall_cnt, exp_stall);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
